// File: rtl/umi_rx_arb_pkg.sv
// umi_rx_arb_pkg: shared constants for the multi-channel UMI RX arbiter.
// Valid-throttle mode encodings, LFSR tap mask and LFSR step helper.
package umi_rx_arb_pkg;

    localparam logic [1:0] VM_EAGER     = 2'd0;
    localparam logic [1:0] VM_RANDOM    = 2'd1;
    localparam logic [1:0] VM_ALTERNATE = 2'd2;

    // Galois form of x^16+x^14+x^13+x^11, right-shifting.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/umi_rx_chan_fifo.sv
// umi_rx_chan_fifo: per-channel first-word-fall-through packet FIFO.
// Ports: clk, rst (async high), push/wdata, pop/rdata, full, empty.
module umi_rx_chan_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !rd_en) count <= count + (PW+1)'(1);
            else if (!wr_en && rd_en) count <= count - (PW+1)'(1);
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/umi_rx_arb_sim.sv
// umi_rx_arb_sim: buffers NCH UMI streams and merges them round-robin.
// Ports: in_* per-channel streams, valid_mode throttle, UMI output + chan.
module umi_rx_arb_sim
    import umi_rx_arb_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          DEPTH     = 4,
    parameter int          DW        = 256,
    parameter int          AW        = 64,
    parameter int          CW        = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*DW-1:0]       in_data,
    input  logic [NCH*AW-1:0]       in_srcaddr,
    input  logic [NCH*AW-1:0]       in_dstaddr,
    input  logic [NCH*CW-1:0]       in_cmd,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    input  logic [1:0]              valid_mode,
    output logic [DW-1:0]           data,
    output logic [AW-1:0]           srcaddr,
    output logic [AW-1:0]           dstaddr,
    output logic [CW-1:0]           cmd,
    output logic                    valid,
    input  logic                    ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] chan
);

    localparam int W   = DW + 2*AW + CW;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [W-1:0]   head [NCH];

    logic [CHW-1:0] rr;
    logic [CHW-1:0] gnt;
    logic [CHW-1:0] idx;
    logic           found;
    logic [15:0]    lfsr;
    logic           tog;
    logic           gate;
    logic           load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push[i] = in_valid[i] & ~full[i];
        assign pop[i]  = load & (gnt == CHW'(i));

        umi_rx_chan_fifo #(
            .DEPTH (DEPTH),
            .W     (W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .wdata ({in_cmd[i*CW +: CW], in_dstaddr[i*AW +: AW],
                     in_srcaddr[i*AW +: AW], in_data[i*DW +: DW]}),
            .pop   (pop[i]),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign in_ready = ~full;

    always_comb begin
        case (valid_mode)
            VM_EAGER:     gate = 1'b1;
            VM_RANDOM:    gate = lfsr[0];
            VM_ALTERNATE: gate = tog;
            default:      gate = 1'b1;
        endcase
    end

    // Rotating search: rr holds the channel after the last grant.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = rr;
        for (int k = 0; k < NCH; k++) begin
            if (!found && !empty[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
            idx = (idx == CHW'(NCH-1)) ? '0 : idx + CHW'(1);
        end
    end

    // The gate only blocks new loads; a presented packet is never withdrawn.
    assign load = (~valid | ready) & gate & found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            srcaddr <= '0;
            dstaddr <= '0;
            cmd     <= '0;
            chan    <= '0;
            rr      <= '0;
            lfsr    <= LFSR_SEED;
            tog     <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            tog  <= ~tog;
            if (load) begin
                valid <= 1'b1;
                {cmd, dstaddr, srcaddr, data} <= head[gnt];
                chan  <= gnt;
                rr    <= (gnt == CHW'(NCH-1)) ? '0 : gnt + CHW'(1);
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_umi_rx_arb_sim.sv
// tb_umi_rx_arb_sim: directed + randomized checks against a queue model.
// Ports: none (drives and observes umi_rx_arb_sim with NCH=3, DEPTH=4).
module tb_umi_rx_arb_sim;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int CW    = 8;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } pkt_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH*AW-1:0] in_srcaddr = '0;
    logic [NCH*AW-1:0] in_dstaddr = '0;
    logic [NCH*CW-1:0] in_cmd = '0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH-1:0]    in_ready;
    logic [1:0]        valid_mode = 2'd0;
    logic [DW-1:0]     data;
    logic [AW-1:0]     srcaddr;
    logic [AW-1:0]     dstaddr;
    logic [CW-1:0]     cmd;
    logic              valid;
    logic              ready = 1'b0;
    logic [1:0]        chan;

    int checks = 0;
    int errors = 0;

    umi_rx_arb_sim #(
        .NCH(NCH), .DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_srcaddr (in_srcaddr),
        .in_dstaddr (in_dstaddr),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .valid_mode (valid_mode),
        .data       (data),
        .srcaddr    (srcaddr),
        .dstaddr    (dstaddr),
        .cmd        (cmd),
        .valid      (valid),
        .ready      (ready),
        .chan       (chan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    pkt_t          q [NCH][$];
    logic          m_valid;
    pkt_t          m_pkt;
    int            m_chan;
    int            m_start;
    logic [15:0]   m_lfsr;
    logic          m_tog;
    logic [NCH-1:0] m_rdy;

    always @(posedge clk or posedge rst) begin : model
        int   sz [NCH];
        int   g;
        int   c;
        logic open;
        pkt_t p;
        if (rst) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
            m_valid = 1'b0;
            m_pkt   = '0;
            m_chan  = 0;
            m_start = 0;
            m_lfsr  = 16'hACE1;
            m_tog   = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) sz[i] = q[i].size();
            case (valid_mode)
                2'd1:    open = m_lfsr[0];
                2'd2:    open = m_tog;
                default: open = 1'b1;
            endcase
            g = -1;
            for (int k = 0; k < NCH; k++) begin
                c = (m_start + k) % NCH;
                if (g < 0 && sz[c] > 0) g = c;
            end
            if ((!m_valid || ready) && open && g >= 0) begin
                m_pkt   = q[g].pop_front();
                m_valid = 1'b1;
                m_chan  = g;
                m_start = (g + 1) % NCH;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && sz[i] < DEPTH) begin
                    p.data = in_data[i*DW +: DW];
                    p.src  = in_srcaddr[i*AW +: AW];
                    p.dst  = in_dstaddr[i*AW +: AW];
                    p.cmd  = in_cmd[i*CW +: CW];
                    q[i].push_back(p);
                end
            end
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_tog  = ~m_tog;
            for (int i = 0; i < NCH; i++) m_rdy[i] = (q[i].size() < DEPTH);
            #1;
            chk("valid", {63'd0, valid}, {63'd0, m_valid});
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            if (m_valid) begin
                chk("data", 64'(data), 64'(m_pkt.data));
                chk("srcaddr", 64'(srcaddr), 64'(m_pkt.src));
                chk("dstaddr", 64'(dstaddr), 64'(m_pkt.dst));
                chk("cmd", 64'(cmd), 64'(m_pkt.cmd));
                chk("chan", 64'(chan), 64'(m_chan));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input int c, input logic [31:0] d);
        in_data[c*DW +: DW]    = d;
        in_srcaddr[c*AW +: AW] = d[15:0] ^ 16'h1111;
        in_dstaddr[c*AW +: AW] = d[31:16];
        in_cmd[c*CW +: CW]     = d[7:0] ^ 8'h5A;
    endtask

    task automatic put_rand();
        for (int c = 0; c < NCH; c++) begin
            in_data[c*DW +: DW]    = $urandom;
            in_srcaddr[c*AW +: AW] = AW'($urandom);
            in_dstaddr[c*AW +: AW] = AW'($urandom);
            in_cmd[c*CW +: CW]     = CW'($urandom);
        end
    endtask

    // Reset lands between edges to observe the asynchronous clear.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_valid = '0;
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'h7);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_chan", 64'(chan), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        int cnt;
        int waited;
        logic [31:0] d;

        // Single channel latency and ordering on channel 1.
        do_reset();
        valid_mode = 2'd0;
        ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                d = 32'hA100_0000 + 32'(k - 2);
                chk("lat_valid", {63'd0, valid}, 64'd1);
                chk("lat_data", 64'(data), 64'(d));
                chk("lat_chan", 64'(chan), 64'd1);
            end
            if (k == 6) chk("lat_empty", {63'd0, valid}, 64'd0);
            if (k < 4) begin
                put(1, 32'hA100_0000 + 32'(k));
                in_valid = 3'b010;
            end else begin
                in_valid = '0;
            end
        end

        // Fairness with every channel continuously valid.
        do_reset();
        ready = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("rr_valid", {63'd0, valid}, 64'd1);
                chk("rr_chan", 64'(chan), 64'((k - 2) % 3));
            end
            for (int c = 0; c < NCH; c++) put(c, {8'(c), 24'(k)});
            in_valid = 3'b111;
        end
        in_valid = '0;

        // Backpressure: slot plus a full FIFO hold five packets.
        do_reset();
        ready = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("bp_valid", {63'd0, valid}, 64'd1);
                chk("bp_data", 64'(data), 64'h00000000B0000000);
            end
            if (k == 4) chk("bp_rdy4", {63'd0, in_ready[0]}, 64'd1);
            if (k >= 5) chk("bp_full", {63'd0, in_ready[0]}, 64'd0);
            if (k < 10) begin
                put(0, 32'hB000_0000 + 32'(k));
                in_valid = 3'b001;
            end else begin
                in_valid = '0;
                ready = 1'b1;
            end
        end
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j <= 4) begin
                chk("drain_valid", {63'd0, valid}, 64'd1);
                chk("drain_data", 64'(data), 64'(32'hB000_0000 + 32'(j)));
            end else begin
                chk("drain_empty", {63'd0, valid}, 64'd0);
            end
        end

        // Alternate mode halves throughput on a saturated channel.
        do_reset();
        valid_mode = 2'd2;
        ready = 1'b1;
        cnt = 0;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (k >= 6 && valid) cnt++;
            put(0, 32'hD000_0000 + 32'(k));
            in_valid = 3'b001;
        end
        in_valid = '0;
        chk("alt_count", 64'(cnt), 64'd10);

        // Random-mode load, then switch to eager while held.
        do_reset();
        valid_mode = 2'd1;
        ready = 1'b0;
        @(negedge clk);
        put(2, 32'hC0DE_0002);
        in_valid = 3'b100;
        @(negedge clk);
        in_valid = '0;
        waited = 0;
        while (!valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("hold_seen", {63'd0, valid}, 64'd1);
        valid_mode = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, valid}, 64'd1);
            chk("hold_data", 64'(data), 64'h00000000C0DE0002);
            chk("hold_chan", 64'(chan), 64'd2);
        end
        ready = 1'b1;

        // Randomized traffic, with a mid-stream reset over queued packets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 150 == 0) valid_mode = 2'($urandom);
            put_rand();
            in_valid = NCH'($urandom);
            ready = ($urandom % 4) != 0;
            if (i == 1500) begin
                ready = 1'b0;
                in_valid = 3'b111;
                repeat (5) @(negedge clk);
                do_reset();
                valid_mode = 2'd0;
                ready = 1'b1;
                @(negedge clk);
                put_rand();
                in_valid = 3'b111;
                @(negedge clk);
                in_valid = '0;
                @(negedge clk);
                chk("post_rst_valid", {63'd0, valid}, 64'd1);
                chk("post_rst_chan", 64'(chan), 64'd0);
            end
        end
        in_valid = '0;
        ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
